rate_meter: RTL
===============

RATE_METER -- requirements
Module: rate_meter

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent event channels, 1..16.
REQ-002 Parameter CNT_W, default 20: width of each per-channel count, 4..32.
REQ-003 Parameter GATE_CYCLES, default 50_000_000: measurement window length in clk cycles, >=4.
REQ-004 Parameter EDGE_MODE, default 0: counted edge, 0=rising, 1=falling, 2=both.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 clr  in  1  synchronous restart: abort the current window and clear the peaks.
REQ-008 en  in  1  count enable; gate timer and accumulators hold while low.
REQ-009 ev_in  in  NUM_CH  asynchronous event inputs, bit i = channel i.
REQ-010 rate_o  out  NUM_CH*CNT_W  last completed window count per channel; channel i at bits [i*CNT_W +: CNT_W].
REQ-011 peak_o  out  NUM_CH*CNT_W  maximum rate_o value per channel since reset or clr; same packing.
REQ-012 ovf_o  out  NUM_CH  per channel, set when the last completed window saturated.
REQ-013 valid_o  out  1  one-cycle pulse when rate_o, peak_o and ovf_o update.

Function
REQ-014 Each ev_in bit passes through a 2-flop synchronizer and then a third history flop; edge_i is decoded from sync2 and hist per EDGE_MODE.
REQ-015 Latency: a level change sampled on clk edge k produces edge_i during the cycle after edge k+2.
REQ-016 The gate counter runs 0..GATE_CYCLES-1 while en=1 and wraps to 0; it holds its value while en=0.
REQ-017 The terminal cycle is any en=1 cycle with gate counter = GATE_CYCLES-1.
REQ-018 In a non-terminal en=1 cycle, the accumulator acc_i increments on edge_i and saturates at 2^CNT_W-1.
REQ-019 An edge_i that would exceed saturation sets ovf_pend_i.
REQ-020 On the terminal cycle, acc_i plus the terminal-cycle edge_i is written to rate_i, saturated; no edge is dropped at the window boundary.
REQ-021 In the same terminal cycle: acc_i <= 0; ovf_o[i] <= ovf_pend_i OR a saturation occurring in this cycle; ovf_pend_i <= 0.
REQ-022 valid_o is registered: it is 1 in the cycle after the terminal cycle and 0 otherwise; rate_o, ovf_o and peak_o change on that same edge.
REQ-023 peak_i <= max(peak_i, new rate_i) on each update (unsigned compare).
REQ-024 While en=0: edges are ignored, acc_i holds, and no valid_o is produced.
REQ-025 clr=1 (priority over en): gate counter <= 0, acc_i <= 0, ovf_pend_i <= 0, peak_i <= 0, and valid_o is suppressed.
REQ-026 clr does not modify rate_o or ovf_o.
REQ-027 The synchronizers are unaffected by clr.
REQ-028 Channels are fully independent; simultaneous edges on all channels are each counted.
REQ-029 Arithmetic is unsigned CNT_W; the gate counter width is clog2(GATE_CYCLES).

Reset
REQ-030 While rst=1, asynchronously: rate_o=0, peak_o=0, ovf_o=0, valid_o=0, gate counter=0, acc=0, ovf_pend=0, synchronizer and history flops=0.
REQ-031 After rst deasserts, the first window starts on the first en=1 cycle.
REQ-032 A rst asserted mid-window discards the partial counts; no valid_o is produced for the aborted window.

Verification
REQ-033 Setup NUM_CH=2, CNT_W=8, GATE_CYCLES=100, EDGE_MODE=0, en=1: a ch0 square wave of period 10 -> valid_o every 100 cycles, rate ch0=10, ch1=0, ovf=0.
REQ-034 EDGE_MODE=2, same ch0 stimulus -> rate ch0=20.
REQ-035 ch1 toggled every cycle with EDGE_MODE=2, CNT_W=6 -> rate ch1=63, ovf_o[1]=1; the following window with the toggling stopped -> rate ch1=0, ovf_o[1]=0, peak ch1 remains 63.
REQ-036 A single ch0 edge placed so that edge_0 falls exactly on the terminal cycle -> it is counted in the closing window (rate=1), and the next window reads 0.
REQ-037 en held low for 37 cycles mid-window with ch0 active -> the valid_o pulse is delayed by 37 cycles and the edges during en=0 are not counted.
REQ-038 clr pulsed at gate count 50 -> peak_o stays 0 until the next update, that update arrives 100 cycles after the clr, and rate_o is unchanged until then; rst asserted mid-window -> all outputs 0 at once, with no stray valid_o.

Source files
------------

// File: rtl/rate_meter.sv
// rate_meter: per-channel event rate meter.
// Counts synchronized edges on each event input over a fixed gate window,
// publishes the count at the end of every window, and tracks the peak
// count and window saturation for each channel.

module rate_meter #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 20,
    parameter int GATE_CYCLES = 50_000_000,
    parameter int EDGE_MODE   = 0           // 0 = rising, 1 = falling, 2 = both
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic [NUM_CH-1:0]       ev_in,
    output logic [NUM_CH*CNT_W-1:0] rate_o,
    output logic [NUM_CH*CNT_W-1:0] peak_o,
    output logic [NUM_CH-1:0]       ovf_o,
    output logic                    valid_o
);

    localparam int                GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;

    // ------------------------------------------------------------------
    // Input synchronization and edge detection
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sync2;
    logic [NUM_CH-1:0] hist;
    logic [NUM_CH-1:0] edge_dec;
    logic [NUM_CH-1:0] edge_q;

    // Decode the selected edge type from the synchronized level and its history.
    // NOTE: every output of a combinational block gets a default assignment up
    // front so no path leaves it unassigned and a latch cannot be inferred.
    always_comb begin
        edge_dec = sync2 & ~hist;
        if (EDGE_MODE == EDGE_FALL) begin
            edge_dec = ~sync2 & hist;
        end else if (EDGE_MODE != EDGE_RISE) begin
            edge_dec = sync2 ^ hist;
        end
    end

    // Two-flop synchronizer, history flop and registered edge pulse; clr does
    // not touch this path so no input edge is lost across a restart.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, as real registers do.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            hist   <= '0;
            edge_q <= '0;
        end else begin
            sync1  <= ev_in;
            sync2  <= sync1;
            hist   <= sync2;
            edge_q <= edge_dec;
        end
    end

    // ------------------------------------------------------------------
    // Gate window timer
    // ------------------------------------------------------------------
    logic [GATE_W-1:0] gate_cnt;
    logic              terminal;

    // The last enabled cycle of a window closes it; clr overrides it.
    assign terminal = en && !clr && (gate_cnt == GATE_LAST);

    // Gate counter: advances only while enabled, wraps at the window end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt <= '0;
        end else if (clr) begin
            gate_cnt <= '0;
        end else if (en) begin
            gate_cnt <= terminal ? '0 : gate_cnt + GATE_W'(1);
        end
    end

    // Window-complete strobe, aligned with the output register update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o <= 1'b0;
        end else begin
            valid_o <= terminal;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel accumulator, result, peak and overflow tracking
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] acc;
        logic [CNT_W-1:0] rate_q;
        logic [CNT_W-1:0] peak_q;
        logic [CNT_W-1:0] rate_nxt;
        logic             ovf_pend;
        logic             ovf_q;
        logic             sat_now;

        // An edge arriving while the accumulator is already full saturates.
        assign sat_now  = edge_q[i] && (acc == CNT_MAX);
        // Closing value folds in the terminal-cycle edge so none is dropped.
        assign rate_nxt = sat_now ? CNT_MAX : acc + CNT_W'(edge_q[i]);

        // Accumulate edges during the window and publish at its end.
        // NOTE: every state register, including the per-channel result and
        // peak registers, is cleared by reset so outputs are known at once.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc      <= '0;
                ovf_pend <= 1'b0;
                rate_q   <= '0;
                peak_q   <= '0;
                ovf_q    <= 1'b0;
            end else if (clr) begin
                acc      <= '0;
                ovf_pend <= 1'b0;
                peak_q   <= '0;
            end else if (terminal) begin
                acc      <= '0;
                ovf_pend <= 1'b0;
                rate_q   <= rate_nxt;
                ovf_q    <= ovf_pend | sat_now;
                if (rate_nxt > peak_q) begin
                    peak_q <= rate_nxt;
                end
            end else if (en && edge_q[i]) begin
                if (sat_now) begin
                    ovf_pend <= 1'b1;
                end else begin
                    acc <= acc + CNT_W'(1);
                end
            end
        end

        assign rate_o[i*CNT_W +: CNT_W] = rate_q;
        assign peak_o[i*CNT_W +: CNT_W] = peak_q;
        assign ovf_o[i]                 = ovf_q;
    end

endmodule
